// File: rtl/per2apb.sv
// Bridge from the peripheral request/grant interconnect to a single APB slave port.
// One transaction in flight; the response is returned one cycle after the APB access completes.
module per2apb #(
    parameter int unsigned PER_ADDR_WIDTH = 32,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned PER_ID_WIDTH   = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic                      per_slave_req_i,
    input  logic [PER_ADDR_WIDTH-1:0] per_slave_add_i,
    input  logic                      per_slave_we_i,
    input  logic [31:0]               per_slave_wdata_i,
    input  logic [3:0]                per_slave_be_i,
    input  logic [PER_ID_WIDTH-1:0]   per_slave_id_i,
    output logic                      per_slave_gnt_o,

    output logic                      per_slave_r_valid_o,
    output logic                      per_slave_r_opc_o,
    output logic [PER_ID_WIDTH-1:0]   per_slave_r_id_o,
    output logic [31:0]               per_slave_r_rdata_o,

    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    state_e                    state_r;
    state_e                    state_s;
    logic                      gnt_s;
    logic                      done_s;

    logic [APB_ADDR_WIDTH-1:0] paddr_r;
    logic [31:0]               pwdata_r;
    logic                      pwrite_r;
    logic [PER_ID_WIDTH-1:0]   id_r;
    logic                      psel_r;
    logic                      penable_r;

    logic                      r_valid_r;
    logic                      r_opc_r;
    logic [PER_ID_WIDTH-1:0]   r_id_r;
    logic [31:0]               r_rdata_r;

    // Byte enables and the address bits above the APB window carry no meaning on APB.
    logic                      unused_s;
    assign unused_s = ^{per_slave_be_i, per_slave_add_i};

    // Grant and access-completion decode; grant is held low while reset is asserted.
    always_comb begin
        gnt_s  = 1'b0;
        done_s = 1'b0;
        if ((state_r == IDLE) && rst_ni) begin
            gnt_s = per_slave_req_i;
        end else begin
            gnt_s = 1'b0;
        end
        if (state_r == ACCESS) begin
            done_s = PREADY;
        end else begin
            done_s = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (gnt_s) begin
                    state_s = SETUP;
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                state_s = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    state_s = IDLE;
                end else begin
                    state_s = ACCESS;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // APB strobes registered from the next state so they line up with the phase.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
        end else begin
            psel_r    <= (state_s != IDLE);
            penable_r <= (state_s == ACCESS);
        end
    end

    // Request capture; the only storage for the outstanding transaction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            paddr_r  <= {APB_ADDR_WIDTH{1'b0}};
            pwdata_r <= 32'h0000_0000;
            pwrite_r <= 1'b0;
            id_r     <= {PER_ID_WIDTH{1'b0}};
        end else if (gnt_s) begin
            paddr_r  <= per_slave_add_i[APB_ADDR_WIDTH-1:0];
            pwdata_r <= per_slave_wdata_i;
            pwrite_r <= per_slave_we_i;
            id_r     <= per_slave_id_i;
        end
    end

    // Response capture: PRDATA/PSLVERR are looked at only in the completing access cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_r <= 1'b0;
            r_opc_r   <= 1'b0;
            r_id_r    <= {PER_ID_WIDTH{1'b0}};
            r_rdata_r <= 32'h0000_0000;
        end else begin
            r_valid_r <= done_s;
            if (done_s) begin
                r_opc_r   <= PSLVERR;
                r_id_r    <= id_r;
                r_rdata_r <= pwrite_r ? 32'h0000_0000 : PRDATA;
            end
        end
    end

    assign per_slave_gnt_o     = gnt_s;
    assign per_slave_r_valid_o = r_valid_r;
    assign per_slave_r_opc_o   = r_opc_r;
    assign per_slave_r_id_o    = r_id_r;
    assign per_slave_r_rdata_o = r_rdata_r;

    assign PADDR   = paddr_r;
    assign PWDATA  = pwdata_r;
    assign PWRITE  = pwrite_r;
    assign PSEL    = psel_r;
    assign PENABLE = penable_r;

endmodule

// File: tb/tb_per2apb.sv
// Directed bench for per2apb: a vector table of single transactions plus
// hand-written back-to-back, reset-abort and narrow-address sequences.
module tb_per2apb;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req;
    logic [31:0] add;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [4:0]  id;
    logic        gnt;
    logic        r_valid;
    logic        r_opc;
    logic [4:0]  r_id;
    logic [31:0] r_rdata;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    logic        gnt12;
    logic        r_valid12;
    logic        r_opc12;
    logic [4:0]  r_id12;
    logic [31:0] r_rdata12;
    logic [11:0] paddr12;
    logic [31:0] pwdata12;
    logic        pwrite12;
    logic        psel12;
    logic        penable12;

    int total  = 0;
    int passed = 0;

    always #5 clk_i = ~clk_i;

    per2apb dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .per_slave_req_i(req), .per_slave_add_i(add), .per_slave_we_i(we),
        .per_slave_wdata_i(wdata), .per_slave_be_i(be), .per_slave_id_i(id),
        .per_slave_gnt_o(gnt), .per_slave_r_valid_o(r_valid), .per_slave_r_opc_o(r_opc),
        .per_slave_r_id_o(r_id), .per_slave_r_rdata_o(r_rdata),
        .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite), .PSEL(psel), .PENABLE(penable),
        .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
    );

    per2apb #(.APB_ADDR_WIDTH(12)) dut12 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .per_slave_req_i(req), .per_slave_add_i(add), .per_slave_we_i(we),
        .per_slave_wdata_i(wdata), .per_slave_be_i(be), .per_slave_id_i(id),
        .per_slave_gnt_o(gnt12), .per_slave_r_valid_o(r_valid12), .per_slave_r_opc_o(r_opc12),
        .per_slave_r_id_o(r_id12), .per_slave_r_rdata_o(r_rdata12),
        .PADDR(paddr12), .PWDATA(pwdata12), .PWRITE(pwrite12), .PSEL(psel12), .PENABLE(penable12),
        .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
    );

    typedef struct {
        logic        we;
        logic [31:0] add;
        logic [31:0] wdata;
        logic [4:0]  id;
        int          waits;
        logic        slverr;
        logic [31:0] prdata;
        logic [31:0] exp_rdata;
        logic        exp_opc;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Starts and ends one time unit after a rising edge with the bridge idle.
    task automatic run_txn(input vec_t v);
        logic [31:0] a;
        a       = v.add;
        req     = 1'b1;
        we      = v.we;
        add     = v.add;
        wdata   = v.wdata;
        id      = v.id;
        pready  = 1'b0;
        prdata  = ~v.prdata;
        pslverr = ~v.slverr;
        @(negedge clk_i);
        chk("gnt_idle", {31'h0, gnt}, 32'h1);
        chk("psel_idle", {31'h0, psel}, 32'h0);
        @(posedge clk_i); #1;
        req   = 1'b0;
        add   = 32'h0000_0000;
        wdata = 32'h0000_0000;
        id    = 5'd0;
        we    = ~v.we;
        @(negedge clk_i);
        chk("setup_psel", {31'h0, psel}, 32'h1);
        chk("setup_penable", {31'h0, penable}, 32'h0);
        chk("setup_paddr", paddr, v.add);
        chk("setup_pwrite", {31'h0, pwrite}, {31'h0, v.we});
        chk("paddr12", {20'h0, paddr12}, {20'h0, a[11:0]});
        if (v.we) chk("setup_pwdata", pwdata, v.wdata);
        for (int w = 0; w <= v.waits; w++) begin
            @(posedge clk_i); #1;
            if (w == v.waits) begin
                pready  = 1'b1;
                prdata  = v.prdata;
                pslverr = v.slverr;
            end
            @(negedge clk_i);
            chk("access_psel", {31'h0, psel}, 32'h1);
            chk("access_penable", {31'h0, penable}, 32'h1);
            chk("access_paddr", paddr, v.add);
            chk("access_rvalid", {31'h0, r_valid}, 32'h0);
        end
        @(posedge clk_i); #1;
        pready  = 1'b0;
        prdata  = 32'h5555_5555;
        pslverr = 1'b0;
        @(negedge clk_i);
        chk("resp_rvalid", {31'h0, r_valid}, 32'h1);
        chk("resp_rdata", r_rdata, v.exp_rdata);
        chk("resp_opc", {31'h0, r_opc}, {31'h0, v.exp_opc});
        chk("resp_id", {27'h0, r_id}, {27'h0, v.id});
        chk("resp_psel", {31'h0, psel}, 32'h0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("rvalid_pulse", {31'h0, r_valid}, 32'h0);
        chk("rdata_hold", r_rdata, v.exp_rdata);
        chk("id_hold", {27'h0, r_id}, {27'h0, v.id});
        @(posedge clk_i); #1;
    endtask

    initial begin
        //         we    add           wdata         id     waits slverr prdata        exp_rdata     exp_opc
        vecs[0] = '{1'b1, 32'h1A10_0004, 32'hDEAD_BEEF, 5'd3,  0, 1'b0, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 32'h1A10_2008, 32'h0000_0000, 5'd7,  3, 1'b0, 32'h1234_5678, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 5'd31, 0, 1'b1, 32'hA5A5_0001, 32'hA5A5_0001, 1'b1};
        vecs[3] = '{1'b1, 32'hFFFF_F123, 32'h0000_0001, 5'd0,  1, 1'b0, 32'h7777_7777, 32'h0000_0000, 1'b0};
        vecs[4] = '{1'b1, 32'h4000_0010, 32'h0BAD_F00D, 5'd12, 2, 1'b1, 32'h1111_2222, 32'h0000_0000, 1'b1};

        rst_ni  = 1'b0;
        req     = 1'b1;
        add     = 32'h1234_5678;
        we      = 1'b1;
        wdata   = 32'hFFFF_FFFF;
        be      = 4'hF;
        id      = 5'd5;
        prdata  = 32'h0000_0000;
        pready  = 1'b1;
        pslverr = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_gnt", {31'h0, gnt}, 32'h0);
        chk("rst_psel", {31'h0, psel}, 32'h0);
        chk("rst_penable", {31'h0, penable}, 32'h0);
        chk("rst_pwrite", {31'h0, pwrite}, 32'h0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pwdata", pwdata, 32'h0);
        chk("rst_rvalid", {31'h0, r_valid}, 32'h0);
        chk("rst_opc", {31'h0, r_opc}, 32'h0);
        chk("rst_rdata", r_rdata, 32'h0);
        chk("rst_rid", {27'h0, r_id}, 32'h0);
        rst_ni = 1'b1;

        // Vector 0 is granted in the first cycle after reset release.
        for (int i = 0; i < 5; i++) run_txn(vecs[i]);

        // Back-to-back reads with the request held high.
        req    = 1'b1;
        we     = 1'b0;
        pready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            id     = 5'(k + 1);
            add    = 32'h2000_0000 + 32'(k * 4);
            prdata = 32'h0000_0100 + 32'(k);
            @(negedge clk_i);
            chk("b2b_gnt", {31'h0, gnt}, 32'h1);
            if (k > 0) begin
                chk("b2b_rvalid", {31'h0, r_valid}, 32'h1);
                chk("b2b_rid", {27'h0, r_id}, 32'(k));
                chk("b2b_rdata", r_rdata, 32'h0000_0100 + 32'(k - 1));
            end
            @(posedge clk_i); #1;
            @(negedge clk_i);
            chk("b2b_gnt_setup", {31'h0, gnt}, 32'h0);
            @(posedge clk_i); #1;
            @(negedge clk_i);
            chk("b2b_gnt_access", {31'h0, gnt}, 32'h0);
            chk("b2b_penable", {31'h0, penable}, 32'h1);
            @(posedge clk_i); #1;
        end
        req = 1'b0;
        @(negedge clk_i);
        chk("b2b_last_rvalid", {31'h0, r_valid}, 32'h1);
        chk("b2b_last_rid", {27'h0, r_id}, 32'd3);
        chk("b2b_last_rdata", r_rdata, 32'h0000_0102);
        @(posedge clk_i); #1;
        pready = 1'b0;

        // Reset asserted while the access phase is stalled.
        req = 1'b1;
        we  = 1'b0;
        id  = 5'd9;
        add = 32'h3000_0040;
        @(posedge clk_i); #1;
        req = 1'b0;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("abort_pre_penable", {31'h0, penable}, 32'h1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("abort_psel", {31'h0, psel}, 32'h0);
        chk("abort_penable", {31'h0, penable}, 32'h0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        pready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            chk("abort_no_rvalid", {31'h0, r_valid}, 32'h0);
            chk("abort_psel_idle", {31'h0, psel}, 32'h0);
            @(posedge clk_i); #1;
        end
        pready = 1'b0;
        run_txn(vecs[1]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/per2apb.md
PER2APB -- requirements
Module: per2apb

Interface
REQ-001 The module SHALL have parameter PER_ADDR_WIDTH, default 32, meaning the peripheral interconnect address width.
REQ-002 The module SHALL have parameter APB_ADDR_WIDTH, default 32, meaning the APB address width; it SHALL be <= PER_ADDR_WIDTH.
REQ-003 The module SHALL have parameter PER_ID_WIDTH, default 5, meaning the transaction ID width.
REQ-004 The module SHALL have one clock and an asynchronous active-low reset: clk_i input 1 (clock); rst_ni input 1 (asynchronous active-low reset).
REQ-005 The module SHALL have per_slave_req_i input 1, the request valid.
REQ-006 The module SHALL have per_slave_add_i input PER_ADDR_WIDTH, the byte address.
REQ-007 The module SHALL have per_slave_we_i input 1, the write enable (1=write).
REQ-008 The module SHALL have per_slave_wdata_i input 32, the write data.
REQ-009 The module SHALL have per_slave_be_i input 4, the byte enables, which are ignored because APB carries no strobes.
REQ-010 The module SHALL have per_slave_id_i input PER_ID_WIDTH, the requester ID.
REQ-011 The module SHALL have per_slave_gnt_o output 1, the request accepted.
REQ-012 The module SHALL have per_slave_r_valid_o output 1, the response valid for one cycle.
REQ-013 The module SHALL have per_slave_r_opc_o output 1, the response error flag (1=error).
REQ-014 The module SHALL have per_slave_r_id_o output PER_ID_WIDTH, the echoed request ID.
REQ-015 The module SHALL have per_slave_r_rdata_o output 32, the read data.
REQ-016 The module SHALL have the APB outputs PADDR APB_ADDR_WIDTH, PWDATA 32, PWRITE 1, PSEL 1 and PENABLE 1.
REQ-017 The module SHALL have the APB inputs PRDATA 32, PREADY 1 and PSLVERR 1.

Function
REQ-018 The FSM SHALL have the states IDLE, SETUP and ACCESS.
REQ-019 per_slave_gnt_o SHALL equal per_slave_req_i only in state IDLE, and SHALL be 0 in SETUP and ACCESS.
REQ-020 On req&gnt, add[APB_ADDR_WIDTH-1:0], wdata, we and id SHALL be registered and the FSM SHALL go IDLE->SETUP.
REQ-021 In SETUP: PSEL=1 and PENABLE=0, and the FSM SHALL go to ACCESS unconditionally.
REQ-022 In ACCESS: PSEL=1 and PENABLE=1; the FSM SHALL hold while PREADY=0 and go to IDLE on PREADY=1.
REQ-023 PADDR, PWDATA and PWRITE SHALL be driven from the registers and stay stable from SETUP through the final ACCESS cycle.
REQ-024 On ACCESS&PREADY, the block SHALL register r_rdata=PRDATA for reads, or 32'h0 for writes; r_opc=PSLVERR; r_id=stored id.
REQ-025 per_slave_r_valid_o SHALL assert for exactly one cycle, in the cycle after ACCESS&PREADY.
REQ-026 r_rdata, r_opc and r_id SHALL hold their values until the next response.
REQ-027 Zero-wait latency SHALL be: grant at cycle T; SETUP at T+1; ACCESS with PREADY at T+2; r_valid at T+3.
REQ-028 Each wait state on PREADY SHALL add one cycle of latency.
REQ-029 In the r_valid cycle the FSM SHALL be in IDLE, so a new request can be granted in the same cycle; simultaneous r_valid and gnt are legal.
REQ-030 Only one transaction SHALL be outstanding, with no buffering beyond the single request register.
REQ-031 PSEL and PENABLE SHALL be 0 in IDLE.
REQ-032 PSLVERR and PRDATA SHALL be sampled only on ACCESS&PREADY.
REQ-033 PRDATA SHALL be ignored for write transactions.
REQ-034 Upper address bits above APB_ADDR_WIDTH SHALL be discarded without error.

Reset
REQ-035 While rst_ni=0: the FSM SHALL be IDLE; PSEL, PENABLE, PWRITE, r_valid and r_opc SHALL be 0; PADDR, PWDATA, r_rdata and r_id SHALL be 0; gnt_o SHALL be forced 0.
REQ-036 Reset asserted mid-transaction SHALL abort it immediately, with no response issued.
REQ-037 After release, the first grant SHALL be possible in the first cycle with rst_ni=1.

Verification
REQ-038 Zero-wait write: req, we=1, add=0x1A10_0004, wdata=0xDEADBEEF, id=3 -> gnt at T; PSEL=1/PENABLE=0 at T+1; PENABLE=1 at T+2; r_valid at T+3 with opc=0, id=3, rdata=0.
REQ-039 Read with 3 PREADY wait cycles, PRDATA=0x12345678 -> ACCESS held 4 cycles; r_valid one cycle later with rdata=0x12345678; PADDR stable throughout.
REQ-040 PSLVERR=1 on a read -> r_opc=1 and rdata=PRDATA, then a subsequent clean write -> r_opc=0.
REQ-041 Back-to-back: req held high for 3 transactions -> gnt only in IDLE cycles; each new gnt coincides with the previous r_valid; IDs are echoed in order.
REQ-042 Reset asserted during ACCESS -> PSEL/PENABLE=0 immediately; no r_valid after release; the next request completes normally.
REQ-043 APB_ADDR_WIDTH=12, add=0xFFFF_F123 -> PADDR=0x123.
